// File: rtl/pixel_bank_writer.sv
// pixel_bank_writer: scatters LANES-pixel words column-interleaved (bank = col mod BANKS) over BANKS memories.
// Writes are registered 1 cycle after acceptance; in_ready only while RUN. PBW_OVERRUN_DET_EN builds overrun detection.
module pixel_bank_writer #(
  parameter int PIX_W  = 8,
  parameter int LANES  = 4,
  parameter int BANKS  = 4,
  parameter int ADDR_W = 17,
  parameter int DIM_W  = 10
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    start,
  input  logic [DIM_W-1:0]        rows,
  input  logic [DIM_W-1:0]        cols,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [LANES*PIX_W-1:0]  pixels,
  output logic [BANKS-1:0]        write_en,
  output logic [BANKS*ADDR_W-1:0] address,
  output logic [BANKS*PIX_W-1:0]  out_data,
  output logic [31:0]             current_pixel,
  output logic [DIM_W-1:0]        row_idx,
  output logic [DIM_W-1:0]        col_idx,
  output logic                    busy,
  output logic                    frame_done,
  output logic                    cfg_err,
  output logic                    overrun
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [63:0]      WORD_SPAN = 64'd1 << ADDR_W;
  localparam logic [DIM_W-1:0] LANES_D   = DIM_W'(LANES);

  state_t             state;
  logic [DIM_W-1:0]   rows_q;
  logic [DIM_W-1:0]   cols_q;
  logic [2*DIM_W-1:0] area;
  logic               geom_ok;
  logic               start_ok;
  logic               accept;
  logic               last_word;
  logic               row_end;

  assign area     = {{DIM_W{1'b0}}, rows} * {{DIM_W{1'b0}}, cols};
  assign geom_ok  = (rows != '0) && (cols != '0) &&
                    ((32'(cols) % 32'(BANKS)) == 32'd0) &&
                    ((64'(area) / 64'(BANKS)) <= WORD_SPAN);
  assign start_ok = (state == IDLE) && start && geom_ok;
  assign accept   = in_valid && in_ready;
  assign row_end  = (col_idx == cols_q - LANES_D);
  assign last_word = row_end && (row_idx == rows_q - DIM_W'(1));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      rows_q        <= '0;
      cols_q        <= '0;
      in_ready      <= 1'b0;
      busy          <= 1'b0;
      frame_done    <= 1'b0;
      cfg_err       <= 1'b0;
      current_pixel <= '0;
      row_idx       <= '0;
      col_idx       <= '0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          if (start_ok) begin
            state         <= RUN;
            in_ready      <= 1'b1;
            busy          <= 1'b1;
            rows_q        <= rows;
            cols_q        <= cols;
            cfg_err       <= 1'b0;
            current_pixel <= '0;
            row_idx       <= '0;
            col_idx       <= '0;
          end else if (start) begin
            cfg_err <= 1'b1;
          end
        end
        RUN: begin
          if (accept) begin
            current_pixel <= current_pixel + 32'(LANES);
            if (row_end) begin
              col_idx <= '0;
              row_idx <= row_idx + DIM_W'(1);
            end else begin
              col_idx <= col_idx + LANES_D;
            end
            // frame_done rises together with the last word's write strobe
            if (last_word) begin
              state      <= DONE;
              in_ready   <= 1'b0;
              frame_done <= 1'b1;
            end
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // cols is a multiple of BANKS, so the running pixel count gives both bank and word address
  logic [31:0]            lane_base;
  logic [ADDR_W-1:0]      word_addr;
  logic [BANKS-1:0]       bank_hit;
  logic [BANKS*PIX_W-1:0] bank_pix;

  assign lane_base = current_pixel % 32'(BANKS);
  assign word_addr = ADDR_W'(current_pixel / 32'(BANKS));

  always_comb begin
    bank_hit = '0;
    bank_pix = '0;
    for (int b = 0; b < BANKS; b++) begin
      for (int l = 0; l < LANES; l++) begin
        if (lane_base + 32'(l) == 32'(b)) begin
          bank_hit[b]                 = 1'b1;
          bank_pix[b*PIX_W +: PIX_W]  = pixels[l*PIX_W +: PIX_W];
        end
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      write_en <= '0;
      address  <= '0;
      out_data <= '0;
    end else begin
      write_en <= accept ? bank_hit : '0;
      for (int b = 0; b < BANKS; b++) begin
        if (accept && bank_hit[b]) begin
          address[b*ADDR_W +: ADDR_W] <= word_addr;
          out_data[b*PIX_W +: PIX_W]  <= bank_pix[b*PIX_W +: PIX_W];
        end
      end
    end
  end

`ifdef PBW_OVERRUN_DET_EN
  logic done_once;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      overrun   <= 1'b0;
      done_once <= 1'b0;
    end else begin
      if (state == DONE) begin
        done_once <= 1'b1;
      end
      if (start_ok) begin
        overrun <= 1'b0;
      end else if (in_valid && ((state == DONE) || ((state == IDLE) && done_once))) begin
        overrun <= 1'b1;
      end
    end
  end
`else
  assign overrun = 1'b0;
`endif

endmodule

// File: tb/tb_pixel_bank_writer.sv
// Scoreboard bench for pixel_bank_writer: LANES=2/BANKS=4 main instance plus a LANES=4, ADDR_W=4 instance for geometry limits.
module tb_pixel_bank_writer;
  localparam int PIX_W = 8, LANES = 2, BANKS = 4, ADDR_W = 17, DIM_W = 10;
  localparam int L4 = 4, A4 = 4;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  logic                    start, in_valid, in_ready, busy, frame_done, cfg_err, overrun;
  logic [DIM_W-1:0]        rows, cols, row_idx, col_idx;
  logic [LANES*PIX_W-1:0]  pixels;
  logic [BANKS-1:0]        write_en;
  logic [BANKS*ADDR_W-1:0] address;
  logic [BANKS*PIX_W-1:0]  out_data;
  logic [31:0]             current_pixel;

  logic                    start4, in_valid4, in_ready4, busy4, frame_done4, cfg_err4, overrun4;
  logic [DIM_W-1:0]        rows4, cols4, row_idx4, col_idx4;
  logic [L4*PIX_W-1:0]     pixels4;
  logic [BANKS-1:0]        write_en4;
  logic [BANKS*A4-1:0]     address4;
  logic [BANKS*PIX_W-1:0]  out_data4;
  logic [31:0]             current_pixel4;

  pixel_bank_writer #(.PIX_W(PIX_W), .LANES(LANES), .BANKS(BANKS), .ADDR_W(ADDR_W), .DIM_W(DIM_W)) u_dut (
    .clock(clock), .reset(reset), .start(start), .rows(rows), .cols(cols),
    .in_valid(in_valid), .in_ready(in_ready), .pixels(pixels),
    .write_en(write_en), .address(address), .out_data(out_data),
    .current_pixel(current_pixel), .row_idx(row_idx), .col_idx(col_idx),
    .busy(busy), .frame_done(frame_done), .cfg_err(cfg_err), .overrun(overrun)
  );

  pixel_bank_writer #(.PIX_W(PIX_W), .LANES(L4), .BANKS(BANKS), .ADDR_W(A4), .DIM_W(DIM_W)) u_dut4 (
    .clock(clock), .reset(reset), .start(start4), .rows(rows4), .cols(cols4),
    .in_valid(in_valid4), .in_ready(in_ready4), .pixels(pixels4),
    .write_en(write_en4), .address(address4), .out_data(out_data4),
    .current_pixel(current_pixel4), .row_idx(row_idx4), .col_idx(col_idx4),
    .busy(busy4), .frame_done(frame_done4), .cfg_err(cfg_err4), .overrun(overrun4)
  );

  typedef struct {
    logic [BANKS-1:0]        we;
    logic [BANKS*ADDR_W-1:0] addr;
    logic [BANKS*PIX_W-1:0]  data;
  } wr_t;

  wr_t                     exp_q[$];
  logic [BANKS*ADDR_W-1:0] sh_addr;
  logic [BANKS*PIX_W-1:0]  sh_data;
  int                      n_vec = 0;
  int                      n_err = 0;
  int                      fd_cnt = 0;
  logic                    exp_ovr;

  logic [15:0] w_tab  [8] = '{16'hBBAA, 16'hDDCC, 16'h1100, 16'h3322, 16'h5544, 16'h7766, 16'h9988, 16'hFFEE};
  logic [3:0]  we_tab [8] = '{4'b0011, 4'b1100, 4'b0011, 4'b1100, 4'b0011, 4'b1100, 4'b0011, 4'b1100};
  int          a_tab  [8] = '{0, 0, 1, 1, 2, 2, 3, 3};

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // shadow of the bank buses: banks not written keep their last address/data
  task automatic push_exp(input logic [BANKS-1:0] we, input logic [ADDR_W-1:0] a, input logic [LANES*PIX_W-1:0] w);
    wr_t e;
    int  l;
    l = 0;
    for (int b = 0; b < BANKS; b++) begin
      if (we[b]) begin
        sh_addr[b*ADDR_W +: ADDR_W] = a;
        sh_data[b*PIX_W +: PIX_W]   = w[l*PIX_W +: PIX_W];
        l++;
      end
    end
    e.we   = we;
    e.addr = sh_addr;
    e.data = sh_data;
    exp_q.push_back(e);
  endtask

  task automatic start_frame(input int r, input int c);
    rows  = DIM_W'(r);
    cols  = DIM_W'(c);
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic start4_frame(input int r, input int c);
    rows4  = DIM_W'(r);
    cols4  = DIM_W'(c);
    start4 = 1'b1;
    tick();
    start4 = 1'b0;
  endtask

  task automatic send_word(input logic [15:0] w, input logic [3:0] we, input int a);
    int waited;
    waited = 0;
    while (!in_ready && waited < 20) begin
      tick();
      waited++;
    end
    if (!in_ready) begin
      check("in_ready_timeout", 128'(in_ready), 128'(1));
    end else begin
      push_exp(we, ADDR_W'(a), w);
      in_valid = 1'b1;
      pixels   = w;
      tick();
      in_valid = 1'b0;
      pixels   = 16'hDEAD;
    end
  endtask

  initial begin
    forever begin
      @(negedge clock);
      if (!reset) begin
        if (frame_done) fd_cnt++;
        if (write_en != '0) begin
          if (exp_q.size() == 0) begin
            check("unexpected_write", 128'(write_en), 128'(0));
          end else begin
            wr_t e;
            e = exp_q.pop_front();
            check("wr_en", 128'(write_en), 128'(e.we));
            check("wr_addr", 128'(address), 128'(e.addr));
            check("wr_data", 128'(out_data), 128'(e.data));
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
`ifdef PBW_OVERRUN_DET_EN
    exp_ovr = 1'b1;
`else
    exp_ovr = 1'b0;
`endif
    start = 0; rows = 0; cols = 0; in_valid = 0; pixels = 0;
    start4 = 0; rows4 = 0; cols4 = 0; in_valid4 = 0; pixels4 = 0;
    sh_addr = '0; sh_data = '0;

    tick();
    reset = 1'b0;
    check("rst_we", 128'(write_en), 128'(0));
    check("rst_addr", 128'(address), 128'(0));
    check("rst_data", 128'(out_data), 128'(0));
    check("rst_counters", {current_pixel, row_idx, col_idx}, 128'(0));
    check("rst_flags", {in_ready, busy, frame_done, cfg_err, overrun}, 128'(0));
    tick();

    start_frame(2, 8);
    check("start_busy", {busy, in_ready, cfg_err}, 128'(3'b110));
    for (int k = 0; k < 3; k++) send_word(w_tab[k], we_tab[k], a_tab[k]);
    for (int k = 3; k < 8; k++) begin
      tick();
      send_word(w_tab[k], we_tab[k], a_tab[k]);
    end
    check("done_in_ready", 128'(in_ready), 128'(0));
    check("done_pulse", 128'(frame_done), 128'(1));
    check("done_pixels", 128'(current_pixel), 128'(16));
    tick();
    check("done_pulse_end", 128'(frame_done), 128'(0));
    check("done_count", 128'(fd_cnt), 128'(1));

    in_valid = 1'b1;
    pixels   = 16'h4242;
    tick();
    in_valid = 1'b0;
    check("overrun_set", 128'(overrun), 128'(exp_ovr));
    check("idle_busy", 128'(busy), 128'(0));
    tick();
    check("overrun_sticky", 128'(overrun), 128'(exp_ovr));

    start_frame(0, 8);
    check("err_rows0", {cfg_err, busy}, 128'(2'b10));
    check("overrun_keep_on_bad_start", 128'(overrun), 128'(exp_ovr));
    start_frame(2, 6);
    check("err_cols6", {cfg_err, busy}, 128'(2'b10));
    start_frame(1023, 1020);
    check("err_too_big", {cfg_err, busy}, 128'(2'b10));

    start_frame(2, 8);
    check("restart_flags", {cfg_err, overrun, busy}, 128'(3'b001));
    check("restart_pixels", 128'(current_pixel), 128'(0));
    send_word(16'h2211, 4'b0011, 0);
    send_word(16'h4433, 4'b1100, 0);
    start_frame(1, 4);
    check("start_while_busy", {busy, cfg_err}, 128'(2'b10));
    check("start_while_busy_px", 128'(current_pixel), 128'(4));
    send_word(16'h6655, 4'b0011, 1);
    check("mid_pixels", 128'(current_pixel), 128'(6));
    check("mid_row_col", {row_idx, col_idx}, {DIM_W'(0), DIM_W'(6)});
    tick();

    reset = 1'b1;
    #1;
    check("abort_async", {write_en, busy, in_ready}, 128'(0));
    tick();
    reset   = 1'b0;
    sh_addr = '0;
    sh_data = '0;
    check("abort_counters", {current_pixel, row_idx, col_idx}, 128'(0));
    check("abort_flags", {busy, in_ready, frame_done, cfg_err, overrun}, 128'(0));
    repeat (4) tick();
    check("abort_no_done", 128'(fd_cnt), 128'(1));

    start4_frame(1, 6);
    check("l4_err_cols6", {cfg_err4, busy4}, 128'(2'b10));
    start4_frame(1, 8);
    check("l4_ok", {cfg_err4, busy4}, 128'(2'b01));
    in_valid4 = 1'b1;
    pixels4   = 32'h44332211;
    tick();
    check("l4_w0", {write_en4, address4, out_data4}, {4'hF, 16'h0000, 32'h44332211});
    pixels4 = 32'h88776655;
    tick();
    in_valid4 = 1'b0;
    check("l4_w1", {write_en4, address4, out_data4}, {4'hF, 16'h1111, 32'h88776655});
    check("l4_done", {frame_done4, in_ready4}, 128'(2'b10));
    tick();
    start4_frame(9, 8);
    check("l4_err_span", {cfg_err4, busy4}, 128'(2'b10));
    start4_frame(8, 8);
    check("l4_span_edge_ok", {cfg_err4, busy4}, 128'(2'b01));

    start_frame(515, 1020);
    check("err_span", {cfg_err, busy}, 128'(2'b10));
    start_frame(514, 1020);
    check("span_ok", {cfg_err, busy}, 128'(2'b01));

    repeat (3) tick();
    check("queue_empty", 128'(exp_q.size()), 128'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
